io_key_input: RTL and testbench

- Memory-mapped key-input peripheral on the CPU's IO bus.
- Sits directly upstream of the IO read-data mux.
- Synchronises and debounces the raw push-button inputs, and captures press and release events in sticky write-1-to-clear flag registers.
- Keeps a running press counter and raises a level interrupt. Software polls it instead of sampling raw, bouncing key levels.

---
 rtl/io_key_pkg.sv | 16 +
 rtl/key_debounce.sv | 65 ++++++
 rtl/io_key_input.sv | 105 ++++++++++
 tb/tb_io_key_input.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_key_pkg.sv
// Shared constants for the key-input IO peripheral: register select
// encodings, counter width and the IO address bit that decodes this block.
package io_key_pkg;

    localparam int unsigned IO_DATA_W       = 32;
    localparam int unsigned COUNT_W         = 16;
    localparam int unsigned KEY_IO_ADDR_BIT = 5;

    typedef enum logic [1:0] {
        KEY_REG_LEVEL   = 2'd0,
        KEY_REG_PRESS   = 2'd1,
        KEY_REG_RELEASE = 2'd2,
        KEY_REG_COUNT   = 2'd3
    } key_reg_e;

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchroniser, polarity, debounce counter and stable level,
// with combinational rise/fall strobes on the cycle the stable level flips.
module key_debounce
    import io_key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 3,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             pressed;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_d;
    logic             accept;

    // Synchroniser resets to the raw idle level so "pressed" starts inactive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {2{ACTIVE_LOW}};
        end else begin
            sync_q <= {sync_q[0], key_raw};
        end
    end

    assign pressed = sync_q[1] ^ ACTIVE_LOW;

    always_comb begin
        cnt_d   = '0;
        level_d = level;
        accept  = 1'b0;
        if (pressed != level) begin
            if (cnt_q == CNT_LAST) begin
                accept  = 1'b1;
                level_d = pressed;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            level <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            level <= level_d;
        end
    end

    assign rise_c = accept & pressed;
    assign fall_c = accept & ~pressed;

endmodule

// File: rtl/io_key_input.sv
// Memory-mapped key peripheral: debounced levels, sticky W1C press/release
// flags, a wrapping press counter and a level interrupt on any press flag.
module io_key_input
    import io_key_pkg::*;
#(
    parameter int unsigned N_KEYS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 3,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_KEYS-1:0]    key_raw,
    input  logic [1:0]           sel,
    input  logic                 we,
    input  logic [IO_DATA_W-1:0] wdata,
    output logic [IO_DATA_W-1:0] rdata,
    output logic                 irq
);

    logic [N_KEYS-1:0]    level;
    logic [N_KEYS-1:0]    rise_c;
    logic [N_KEYS-1:0]    fall_c;
    logic [N_KEYS-1:0]    press_q;
    logic [N_KEYS-1:0]    release_q;
    logic [COUNT_W-1:0]   press_count;
    logic [N_KEYS-1:0]    press_d;
    logic [N_KEYS-1:0]    release_d;
    logic [COUNT_W-1:0]   count_d;
    logic [N_KEYS-1:0]    press_clr;
    logic [N_KEYS-1:0]    release_clr;
    logic                 count_wr;
    logic [COUNT_W-1:0]   rise_pop;
    logic [IO_DATA_W-1:0] wdata_unused;

    // Only the low N_KEYS write bits carry meaning.
    assign wdata_unused = wdata;

    for (genvar i = 0; i < int'(N_KEYS); i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_key (
            .clk     (clk),
            .reset   (reset),
            .key_raw (key_raw[i]),
            .level   (level[i]),
            .rise_c  (rise_c[i]),
            .fall_c  (fall_c[i])
        );
    end

    always_comb begin
        press_clr   = '0;
        release_clr = '0;
        count_wr    = 1'b0;
        if (we) begin
            case (key_reg_e'(sel))
                KEY_REG_PRESS:   press_clr   = wdata[N_KEYS-1:0];
                KEY_REG_RELEASE: release_clr = wdata[N_KEYS-1:0];
                KEY_REG_COUNT:   count_wr    = 1'b1;
                default:         ;
            endcase
        end
    end

    always_comb begin
        rise_pop = '0;
        for (int i = 0; i < int'(N_KEYS); i++) begin
            rise_pop = rise_pop + COUNT_W'(rise_c[i]);
        end
    end

    // New events are OR-ed in after the clear, so a same-cycle set wins.
    always_comb begin
        press_d   = (press_q & ~press_clr) | rise_c;
        release_d = (release_q & ~release_clr) | fall_c;
        count_d   = count_wr ? rise_pop : press_count + rise_pop;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_q     <= '0;
            release_q   <= '0;
            press_count <= '0;
            irq         <= 1'b0;
        end else begin
            press_q     <= press_d;
            release_q   <= release_d;
            press_count <= count_d;
            irq         <= |press_q;
        end
    end

    always_comb begin
        rdata = '0;
        case (key_reg_e'(sel))
            KEY_REG_LEVEL:   rdata = IO_DATA_W'(level);
            KEY_REG_PRESS:   rdata = IO_DATA_W'(press_q);
            KEY_REG_RELEASE: rdata = IO_DATA_W'(release_q);
            KEY_REG_COUNT:   rdata = IO_DATA_W'(press_count);
            default:         rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_io_key_input.sv
// Bench for io_key_input: directed scenarios plus random key/bus traffic,
// checked every cycle against a sliding-window reference model.
`timescale 1ns/100ps
module tb_io_key_input;

    localparam int unsigned N = 4;
    localparam int unsigned D = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  key_raw;
    logic [1:0]    sel;
    logic          we;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          irq;

    int checks = 0;
    int errors = 0;

    io_key_input #(
        .N_KEYS          (N),
        .DEBOUNCE_CYCLES (D),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .key_raw (key_raw),
        .sel     (sel),
        .we      (we),
        .wdata   (wdata),
        .rdata   (rdata),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Model: samp[j] = "pressed" vector sampled at the edge j edges ago.
    logic [N-1:0] samp [0:D+1];
    logic [N-1:0] m_level;
    logic [N-1:0] m_press;
    logic [N-1:0] m_release;
    logic [15:0]  m_count;
    logic         m_irq;
    logic [31:0]  snap [0:3];
    logic         snap_irq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int j = 0; j <= int'(D) + 1; j++) samp[j] = '0;
        m_level   = '0;
        m_press   = '0;
        m_release = '0;
        m_count   = '0;
        m_irq     = 1'b0;
    endtask

    // A key's level flips when its last D synchronised samples all disagree with it.
    task automatic model_edge();
        logic [N-1:0] flip;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] pclr;
        logic [N-1:0] rclr;
        logic         all_diff;
        logic         irq_n;
        if (reset) begin
            model_clear();
            return;
        end
        for (int j = int'(D) + 1; j > 0; j--) samp[j] = samp[j-1];
        samp[0] = ~key_raw;
        flip = '0;
        for (int k = 0; k < int'(N); k++) begin
            all_diff = 1'b1;
            for (int j = 2; j <= int'(D) + 1; j++) begin
                if (samp[j][k] == m_level[k]) all_diff = 1'b0;
            end
            flip[k] = all_diff;
        end
        rise      = flip & ~m_level;
        fall      = flip & m_level;
        pclr      = (we && sel == 2'd1) ? wdata[N-1:0] : '0;
        rclr      = (we && sel == 2'd2) ? wdata[N-1:0] : '0;
        irq_n     = |m_press;
        m_press   = (m_press & ~pclr) | rise;
        m_release = (m_release & ~rclr) | fall;
        if (we && sel == 2'd3) m_count = 16'($countones(rise));
        else                   m_count = m_count + 16'($countones(rise));
        m_level   = m_level ^ flip;
        m_irq     = irq_n;
    endtask

    function automatic logic [31:0] model_reg(input logic [1:0] s);
        case (s)
            2'd0:    return 32'(m_level);
            2'd1:    return 32'(m_press);
            2'd2:    return 32'(m_release);
            default: return 32'(m_count);
        endcase
    endfunction

    task automatic set_reset(input logic v);
        reset = v;
        if (v) model_clear();
    endtask

    // One clock: advance the model at the edge, then read back every register mid-low-phase.
    task automatic tick();
        logic [1:0] sel_d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        sel_d = sel;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #0.5;
            snap[s] = rdata;
            chk($sformatf("model_reg%0d", s), rdata, model_reg(2'(s)));
        end
        snap_irq = irq;
        chk("model_irq", 32'(irq), 32'(m_irq));
        sel = sel_d;
    endtask

    task automatic lit(input string name, input int idx, input logic [31:0] exp);
        chk(name, snap[idx], exp);
    endtask

    logic [N-1:0] hold;

    initial begin
        reset   = 1'b1;
        key_raw = 4'hF;
        sel     = 2'd0;
        we      = 1'b0;
        wdata   = '0;
        model_clear();

        repeat (3) tick();
        for (int s = 0; s < 4; s++) lit("reset_rdata", s, 32'h0);
        chk("reset_irq", 32'(snap_irq), 32'h0);
        set_reset(1'b0);

        // Clean press of key 0
        key_raw = 4'b1110;
        repeat (4) tick();
        lit("press_level_edge4", 0, 32'h0);
        tick();
        lit("press_level_edge5", 0, 32'h1);
        lit("press_flag_edge5", 1, 32'h1);
        lit("press_count_edge5", 3, 32'h1);
        chk("press_irq_edge5", 32'(snap_irq), 32'h0);
        tick();
        chk("press_irq_edge6", 32'(snap_irq), 32'h1);

        // Two-cycle glitch on key 1
        key_raw = 4'b1100;
        repeat (2) tick();
        key_raw = 4'b1110;
        repeat (10) tick();
        lit("glitch_level", 0, 32'h1);
        lit("glitch_press", 1, 32'h1);
        lit("glitch_count", 3, 32'h1);

        // W1C, then clear colliding with key 2's rise
        we = 1'b1; sel = 2'd1; wdata = 32'h1;
        tick();
        we = 1'b0; sel = 2'd0;
        lit("w1c_press", 1, 32'h0);
        chk("w1c_irq_same", 32'(snap_irq), 32'h1);
        tick();
        chk("w1c_irq_next", 32'(snap_irq), 32'h0);
        key_raw = 4'b1010;
        repeat (4) tick();
        we = 1'b1; sel = 2'd1; wdata = 32'h4;
        tick();
        we = 1'b0; sel = 2'd0;
        lit("collide_press", 1, 32'h4);
        lit("collide_count", 3, 32'h2);

        // Release all, clear flags, then wrap the counter with a two-key press
        key_raw = 4'hF;
        repeat (8) tick();
        we = 1'b1; sel = 2'd1; wdata = 32'hF;
        tick();
        sel = 2'd2;
        tick();
        we = 1'b0; sel = 2'd0;
        lit("clear_press", 1, 32'h0);
        lit("clear_release", 2, 32'h0);
        force dut.press_count = 16'hFFFF;
        #1;
        release dut.press_count;
        m_count = 16'hFFFF;
        key_raw = 4'b0011;
        repeat (5) tick();
        lit("wrap_count", 3, 32'h1);
        lit("wrap_press", 1, 32'hC);
        key_raw = 4'hF;
        repeat (5) tick();
        lit("wrap_release", 2, 32'hC);
        lit("wrap_level", 0, 32'h0);

        // Reset in the middle of a debounce
        key_raw = 4'b1110;
        repeat (4) tick();
        set_reset(1'b1);
        tick();
        for (int s = 0; s < 4; s++) lit("midreset_rdata", s, 32'h0);
        chk("midreset_irq", 32'(snap_irq), 32'h0);
        set_reset(1'b0);
        repeat (4) tick();
        lit("after_reset_press_edge4", 1, 32'h0);
        tick();
        lit("after_reset_press_edge5", 1, 32'h1);
        lit("after_reset_count_edge5", 3, 32'h1);

        // Random key traffic, glitches, bus writes and occasional resets
        hold = key_raw;
        repeat (3000) begin
            if ($urandom_range(7) == 0) hold[$urandom_range(N - 1)] ^= 1'b1;
            key_raw = hold;
            if ($urandom_range(15) == 0) key_raw = hold ^ N'($urandom);
            we    = ($urandom_range(5) == 0);
            sel   = 2'($urandom);
            wdata = $urandom;
            if ($urandom_range(399) == 0) set_reset(1'b1);
            else if (reset)               set_reset(1'b0);
            tick();
        end
        we = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
